// File: rtl/tlb_ctrl.sv
// -----------------------------------------------------------------------------
// tlb_ctrl
//   Lookup / refill / flush controller sitting in front of a set-associative
//   TLB storage array. It issues combinational reads to the storage, compares
//   the requested VPN against every way of the indexed set, ages the per-entry
//   LRU counters after every successful access, fetches missing translations
//   from the page-table walker and refills a victim way. A flush walks every
//   entry and clears it.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_*                    translation request (valid/ready, vpn, access type)
//   resp_*                   translation response (valid/ready, hit, ppn, fault)
//   ptw_*                    page-table walker request / single-cycle response
//   flush, flush_done        full TLB invalidate and its completion pulse
//   rd_*                     storage read port (set index out, per-way data in)
//   wr_*                     storage entry write port
//   lru_*                    storage LRU counter update port
// -----------------------------------------------------------------------------
module tlb_ctrl #(
    parameter int NUM_SETS       = 16,
    parameter int NUM_WAYS       = 4,
    parameter int SET_INDEX_BITS = 4,
    parameter int LRU_BITS       = 4
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [19:0]                    req_vpn,
    input  logic                           req_is_write,

    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic                           resp_hit,
    output logic [19:0]                    resp_ppn,
    output logic                           resp_fault,

    output logic                           ptw_req_valid,
    output logic [19:0]                    ptw_vpn,
    input  logic                           ptw_resp_valid,
    input  logic [19:0]                    ptw_ppn,
    input  logic [1:0]                     ptw_perms,
    input  logic                           ptw_fault,

    input  logic                           flush,
    output logic                           flush_done,

    output logic [SET_INDEX_BITS-1:0]      rd_set_index,
    input  logic [NUM_WAYS-1:0]            rd_valid,
    input  logic [NUM_WAYS*20-1:0]         rd_vpn,
    input  logic [NUM_WAYS*20-1:0]         rd_ppn,
    input  logic [NUM_WAYS*2-1:0]          rd_perms,
    input  logic [NUM_WAYS*LRU_BITS-1:0]   rd_lru_count,

    output logic                           wr_en,
    output logic [SET_INDEX_BITS-1:0]      wr_set_index,
    output logic [1:0]                     wr_way,
    output logic                           wr_valid,
    output logic [19:0]                    wr_vpn,
    output logic [19:0]                    wr_ppn,
    output logic [1:0]                     wr_perms,
    output logic [LRU_BITS-1:0]            wr_lru_count,

    output logic                           lru_update_en,
    output logic [SET_INDEX_BITS-1:0]      lru_set_index,
    output logic [1:0]                     lru_way,
    output logic [LRU_BITS-1:0]            lru_value
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_PTW    = 3'd2,
        ST_REFILL = 3'd3,
        ST_AGE    = 3'd4,
        ST_RESP   = 3'd5,
        ST_FLUSH  = 3'd6
    } state_t;

    localparam logic [1:0]                LAST_WAY = 2'(NUM_WAYS - 1);
    localparam logic [SET_INDEX_BITS-1:0] LAST_SET = SET_INDEX_BITS'(NUM_SETS - 1);
    localparam logic [SET_INDEX_BITS-1:0] SET_ZERO = {SET_INDEX_BITS{1'b0}};
    localparam logic [LRU_BITS-1:0]       LRU_ZERO = {LRU_BITS{1'b0}};
    localparam logic [LRU_BITS-1:0]       LRU_MAX  = {LRU_BITS{1'b1}};
    localparam logic [LRU_BITS-1:0]       LRU_ONE  = LRU_BITS'(1);

    state_t                    state_r;
    state_t                    state_next_s;

    logic [19:0]               vpn_r;
    logic                      is_write_r;
    logic [1:0]                way_r;
    logic [19:0]               ppn_r;
    logic [1:0]                perms_r;
    logic                      hit_r;
    logic [1:0]                age_idx_r;
    logic [SET_INDEX_BITS-1:0] flush_set_r;
    logic [1:0]                flush_way_r;

    logic                      resp_valid_r;
    logic                      resp_hit_r;
    logic [19:0]               resp_ppn_r;
    logic                      resp_fault_r;
    logic                      flush_done_r;

    logic [19:0]               way_vpn_s   [NUM_WAYS];
    logic [19:0]               way_ppn_s   [NUM_WAYS];
    logic [1:0]                way_perms_s [NUM_WAYS];
    logic [LRU_BITS-1:0]       way_lru_s   [NUM_WAYS];

    logic [NUM_WAYS-1:0]       hit_vec_s;
    logic                      lookup_hit_s;
    logic [1:0]                lookup_way_s;
    logic                      any_invalid_s;
    logic [1:0]                invalid_way_s;
    logic [1:0]                max_way_s;
    logic [LRU_BITS-1:0]       max_lru_s;
    logic                      take_s;
    logic [1:0]                victim_way_s;
    logic [LRU_BITS-1:0]       cur_lru_s;
    logic [LRU_BITS-1:0]       aged_value_s;
    logic [SET_INDEX_BITS-1:0] set_idx_s;
    logic                      age_last_s;
    logic                      flush_last_s;

    assign set_idx_s    = vpn_r[SET_INDEX_BITS-1:0];
    assign age_last_s   = (age_idx_r == LAST_WAY);
    assign flush_last_s = (flush_way_r == LAST_WAY) && (flush_set_r == LAST_SET);

    assign resp_valid = resp_valid_r;
    assign resp_hit   = resp_hit_r;
    assign resp_ppn   = resp_ppn_r;
    assign resp_fault = resp_fault_r;
    assign flush_done = flush_done_r;

    // Unpack the flat per-way storage read buses into per-way views.
    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            way_vpn_s[w]   = rd_vpn[w*20 +: 20];
            way_ppn_s[w]   = rd_ppn[w*20 +: 20];
            way_perms_s[w] = rd_perms[w*2 +: 2];
            way_lru_s[w]   = rd_lru_count[w*LRU_BITS +: LRU_BITS];
        end
    end

    // Tag compare and victim selection; descending scans make the lowest way win.
    always_comb begin
        lookup_way_s  = 2'b00;
        invalid_way_s = 2'b00;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec_s[w] = rd_valid[w] && (way_vpn_s[w] == vpn_r);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            lookup_way_s  = hit_vec_s[w] ? 2'(w) : lookup_way_s;
            invalid_way_s = !rd_valid[w] ? 2'(w) : invalid_way_s;
        end
        lookup_hit_s  = |hit_vec_s;
        any_invalid_s = !(&rd_valid);

        // Strict greater-than keeps the lowest index among equal ages.
        max_way_s = 2'b00;
        max_lru_s = way_lru_s[0];
        take_s    = 1'b0;
        for (int w = 1; w < NUM_WAYS; w++) begin
            take_s    = (way_lru_s[w] > max_lru_s);
            max_way_s = take_s ? 2'(w) : max_way_s;
            max_lru_s = take_s ? way_lru_s[w] : max_lru_s;
        end
        victim_way_s = any_invalid_s ? invalid_way_s : max_way_s;
    end

    // Saturating age value for the way currently being updated.
    always_comb begin
        cur_lru_s = way_lru_s[age_idx_r];
        if (age_idx_r == way_r) begin
            aged_value_s = LRU_ZERO;
        end else if (cur_lru_s == LRU_MAX) begin
            aged_value_s = LRU_MAX;
        end else begin
            aged_value_s = cur_lru_s + LRU_ONE;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and state-decoded storage / walker strobes.
    always_comb begin
        state_next_s  = state_r;
        req_ready     = 1'b0;
        ptw_req_valid = 1'b0;
        ptw_vpn       = 20'h0;
        rd_set_index  = (state_r == ST_IDLE) ? SET_ZERO : set_idx_s;
        wr_en         = 1'b0;
        wr_set_index  = SET_ZERO;
        wr_way        = 2'b00;
        wr_valid      = 1'b0;
        wr_vpn        = 20'h0;
        wr_ppn        = 20'h0;
        wr_perms      = 2'b00;
        wr_lru_count  = LRU_ZERO;
        lru_update_en = 1'b0;
        lru_set_index = SET_ZERO;
        lru_way       = 2'b00;
        lru_value     = LRU_ZERO;

        case (state_r)
            ST_IDLE: begin
                // A flush in the same cycle as a request wins and stalls it.
                req_ready = !rst && !flush;
                if (flush) begin
                    state_next_s = ST_FLUSH;
                end else if (req_valid) begin
                    state_next_s = ST_LOOKUP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                state_next_s = lookup_hit_s ? ST_AGE : ST_PTW;
            end
            ST_PTW: begin
                ptw_req_valid = 1'b1;
                ptw_vpn       = vpn_r;
                if (ptw_resp_valid) begin
                    state_next_s = ptw_fault ? ST_RESP : ST_REFILL;
                end else begin
                    state_next_s = ST_PTW;
                end
            end
            ST_REFILL: begin
                wr_en        = 1'b1;
                wr_set_index = set_idx_s;
                wr_way       = victim_way_s;
                wr_valid     = 1'b1;
                wr_vpn       = vpn_r;
                wr_ppn       = ppn_r;
                wr_perms     = perms_r;
                wr_lru_count = LRU_ZERO;
                state_next_s = ST_AGE;
            end
            ST_AGE: begin
                lru_update_en = 1'b1;
                lru_set_index = set_idx_s;
                lru_way       = age_idx_r;
                lru_value     = aged_value_s;
                state_next_s  = age_last_s ? ST_RESP : ST_AGE;
            end
            ST_RESP: begin
                state_next_s = resp_ready ? ST_IDLE : ST_RESP;
            end
            ST_FLUSH: begin
                wr_en        = 1'b1;
                wr_set_index = flush_set_r;
                wr_way       = flush_way_r;
                state_next_s = flush_last_s ? ST_IDLE : ST_FLUSH;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Request latch, translation capture, counters and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpn_r        <= 20'h0;
            is_write_r   <= 1'b0;
            way_r        <= 2'b00;
            ppn_r        <= 20'h0;
            perms_r      <= 2'b00;
            hit_r        <= 1'b0;
            age_idx_r    <= 2'b00;
            flush_set_r  <= SET_ZERO;
            flush_way_r  <= 2'b00;
            resp_valid_r <= 1'b0;
            resp_hit_r   <= 1'b0;
            resp_ppn_r   <= 20'h0;
            resp_fault_r <= 1'b0;
            flush_done_r <= 1'b0;
        end else begin
            flush_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (flush) begin
                        flush_set_r <= SET_ZERO;
                        flush_way_r <= 2'b00;
                    end else if (req_valid) begin
                        vpn_r      <= req_vpn;
                        is_write_r <= req_is_write;
                        age_idx_r  <= 2'b00;
                    end
                end
                ST_LOOKUP: begin
                    hit_r <= lookup_hit_s;
                    if (lookup_hit_s) begin
                        way_r   <= lookup_way_s;
                        ppn_r   <= way_ppn_s[lookup_way_s];
                        perms_r <= way_perms_s[lookup_way_s];
                    end
                end
                ST_PTW: begin
                    if (ptw_resp_valid) begin
                        ppn_r   <= ptw_ppn;
                        perms_r <= ptw_perms;
                        // A walk fault answers directly: no refill, no aging.
                        if (ptw_fault) begin
                            resp_valid_r <= 1'b1;
                            resp_hit_r   <= 1'b0;
                            resp_ppn_r   <= 20'h0;
                            resp_fault_r <= 1'b1;
                        end
                    end
                end
                ST_REFILL: begin
                    // The refilled way becomes the accessed way for aging.
                    way_r <= victim_way_s;
                end
                ST_AGE: begin
                    age_idx_r <= age_idx_r + 2'd1;
                    if (age_last_s) begin
                        age_idx_r    <= 2'b00;
                        resp_valid_r <= 1'b1;
                        resp_hit_r   <= hit_r;
                        resp_ppn_r   <= ppn_r;
                        resp_fault_r <= !perms_r[is_write_r];
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        resp_hit_r   <= 1'b0;
                        resp_ppn_r   <= 20'h0;
                        resp_fault_r <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (flush_way_r == LAST_WAY) begin
                        flush_way_r <= 2'b00;
                        flush_set_r <= flush_set_r + SET_INDEX_BITS'(1);
                    end else begin
                        flush_way_r <= flush_way_r + 2'd1;
                    end
                    if (flush_last_s) begin
                        flush_done_r <= 1'b1;
                    end
                end
                default: begin
                    flush_done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
